// File: rtl/handshake_sync_pkg.sv
// Shared constants and state encoding for the toggle-handshake receive synchroniser.
package handshake_sync_pkg;

  localparam int ACK_LATE  = 0;
  localparam int ACK_EARLY = 1;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

endpackage

// File: rtl/sync_stages.sv
// N-flop single-bit synchroniser for a signal arriving from a foreign clock domain.
module sync_stages #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/handshake_sync_rx.sv
// Multi-channel receive-side toggle-handshake synchroniser with valid/ready output.
// state | meaning:  IDLE | no entry held;  FULL | o_data valid, waiting for consumer
module handshake_sync_rx
  import handshake_sync_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int ACK_MODE    = 0
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [CHANNELS-1:0]       i_req_tgl,
  input  logic [CHANNELS*WIDTH-1:0] i_data,
  output logic [CHANNELS-1:0]       o_ack_tgl,
  output logic [CHANNELS-1:0]       o_valid,
  input  logic [CHANNELS-1:0]       i_ready,
  output logic [CHANNELS*WIDTH-1:0] o_data,
  output logic [CHANNELS-1:0]       o_busy
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic             req_s;
    logic             ack_q;
    logic             pending;
    logic             capture;
    logic             ack_flip;
    logic [WIDTH-1:0] data_q;
    state_t           state;
    state_t           state_nxt;

    sync_stages #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .d     (i_req_tgl[c]),
      .q     (req_s)
    );

    assign pending = req_s ^ ack_q;

    always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      ack_flip  = 1'b0;
      case (state)
        IDLE: begin
          if (pending) begin
            capture   = 1'b1;
            state_nxt = FULL;
            ack_flip  = (ACK_MODE == ACK_EARLY);
          end
        end
        FULL: begin
          if (i_ready[c]) begin
            if (ACK_MODE == ACK_EARLY) begin
              // In early mode pending here means the next word is already announced
              if (pending) begin
                capture  = 1'b1;
                ack_flip = 1'b1;
              end else begin
                state_nxt = IDLE;
              end
            end else begin
              ack_flip  = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        state  <= IDLE;
        ack_q  <= 1'b0;
        data_q <= '0;
      end else begin
        state <= state_nxt;
        ack_q <= ack_q ^ ack_flip;
        if (capture) data_q <= i_data[c*WIDTH +: WIDTH];
      end
    end

    assign o_ack_tgl[c]               = ack_q;
    assign o_valid[c]                 = (state == FULL);
    assign o_data[c*WIDTH +: WIDTH]   = data_q;
    assign o_busy[c]                  = pending | (state == FULL);
  end

endmodule
